ops_seq: RTL and testbench
==========================

Name: ops_seq

Overview:
- Upstream issue/capture stage for the 8-bit `ops` unit (add / mod / and / or).
- Buffers operand commands in a small FIFO and issues one command per cycle into a single `ops` instance.
- Registers the result behind a valid/ready output handshake.
- Guards the mod-by-zero case, whose combinational result is undefined.

Parameters:
- DEPTH, 4, command FIFO depth in entries; power of two, at least 2.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when in_valid && in_ready.
- in_a  in  8  operand a.
- in_b  in  8  operand b.
- in_op  in  2  opcode: 00 add, 01 mod, 10 and, 11 or.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream can take the result.
- out_data  out  8  registered result.
- out_err  out  1  result came from mod with b==0.
- busy  out  1  FIFO non-empty or out_valid set.
- done_cnt  out  CNT_W  count of completed output handshakes.

Behaviour:
- Reset (rst_n low at a clock edge):
  - FIFO pointers and count cleared; FIFO contents discarded.
  - out_valid=0, out_data=0, out_err=0, done_cnt=0.
  - in_ready forced to 0 while rst_n is low.
  - Reset mid-operation drops all queued and pending results; nothing is emitted afterwards.
- FIFO:
  - Entry is {op, b, a}, 18 bits.
  - in_ready = rst_n && !full. No write-through when full.
  - Push when in_valid && in_ready.
  - Push and pop in the same cycle leave the occupancy unchanged; pointers wrap modulo DEPTH.
- Issue condition: issue = !empty && (!out_valid || out_ready).
  - On issue, the head entry drives the ops unit combinationally.
  - At the same edge: pop the FIFO, load out_data and out_err, set out_valid=1.
- Output:
  - Hold out_valid=0 when not issuing and (out_ready || !out_valid).
  - While out_valid && !out_ready, out_data and out_err are held stable.
- Latency and throughput:
  - A command accepted at edge N into an empty FIFO with an idle output produces out_valid high from edge N+1, i.e. visible in the cycle after the FIFO write.
  - Sustained throughput is 1 result per cycle with out_ready held high.
- Arithmetic (8-bit, modular):
  - add: a+b, carry discarded.
  - and, or: bitwise.
  - mod: a%b when b!=0. If b==0, force out_data=8'h00 and out_err=1; the ops output is ignored.
  - out_err=0 for every other case.
- done_cnt: increments on each out_valid && out_ready; wraps at 2^CNT_W.
- busy = !empty || out_valid.
- Ordering: results leave in strict command order; no reordering or dropping except on reset.

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD=2'd0, OP_MOD=2'd1, OP_AND=2'd2, OP_OR=2'd3;
  - the command entry width (18).
- Sub-module ops_cmd_fifo: synchronous FIFO with parameter DEPTH and ports push/pop/full/empty/rd_data.
- ops_seq instantiates ops_cmd_fifo and the existing ops unit; the zero-divisor guard and output register stay in ops_seq.

Test Plan:
- Reset, then one command a=8'd200, b=8'd100, op=00 with out_ready=1 -> out_data=8'd44, out_err=0, out_valid for exactly one cycle, done_cnt=1.
- op=01, a=8'd23, b=8'd5 -> out_data=8'd3. Then op=01, a=8'd23, b=0 -> out_data=8'h00, out_err=1. Next op=10, a=8'hF0, b=8'h3C -> out_data=8'h30, out_err=0.
- out_ready=0, push 5 commands with DEPTH=4:
  - the first issues to the output register, the next 4 fill the FIFO;
  - in_ready falls after the 5th accept; a 6th is stalled;
  - out_data stays at the first result;
  - raise out_ready -> 5 results emerge in order on consecutive cycles, then the 6th.
- Back-to-back stream of 16 op=11 commands with in_valid and out_ready held high:
  - one result per cycle after the first;
  - results in order; done_cnt=16;
  - busy drops the cycle after the last handshake.
- Fill the FIFO with 3 entries plus a held output, then pulse rst_n low for one edge -> out_valid=0, busy=0, done_cnt=0; no stale result appears afterwards.
- Preload done_cnt to 16'hFFFF with 65535 handshakes, or force via bench, then one more handshake -> done_cnt=0.

Source files
------------

// File: rtl/ops_seq_pkg.sv
// Shared definitions for the ops issue/capture stage: opcodes and the command entry layout.
package ops_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_MOD = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

    localparam int unsigned CMD_W = 18;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] b;
        logic [7:0] a;
    } cmd_t;

endpackage

// File: rtl/ops.sv
// Existing combinational 8-bit ops unit: add / mod / and / or.
module ops
    import ops_seq_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [1:0] op,
    output logic [7:0] y
);

    // Result for mod with b == 0 is undefined here; callers must guard it.
    always_comb begin
        y = '0;
        unique case (op)
            OP_ADD:  y = a + b;
            OP_MOD:  y = a % b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/ops_cmd_fifo.sv
// Synchronous command FIFO with registered pointers and occupancy count.
module ops_cmd_fifo
    import ops_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [CMD_W-1:0] wr_data,
    output logic [CMD_W-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ops_seq.sv
// Issue stage for the ops unit: buffers commands, issues one per cycle and
// registers the result behind a valid/ready handshake with a mod-by-zero guard.
module ops_seq
    import ops_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_err,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    logic             full;
    logic             empty;
    logic             issue;
    logic [CMD_W-1:0] rd_data;
    cmd_t             head;
    logic [7:0]       ops_y;
    logic             div_zero;

    assign in_ready = rst_n && !full;
    assign issue    = !empty && (!out_valid || out_ready);
    assign head     = cmd_t'(rd_data);
    assign div_zero = (head.op == OP_MOD) && (head.b == 8'd0);
    assign busy     = !empty || out_valid;

    ops_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (in_valid && in_ready),
        .pop     (issue),
        .wr_data ({in_op, in_b, in_a}),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty)
    );

    ops u_ops (
        .a  (head.a),
        .b  (head.b),
        .op (head.op),
        .y  (ops_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            done_cnt  <= '0;
        end else begin
            if (out_valid && out_ready) done_cnt <= done_cnt + CNT_W'(1);
            if (issue) begin
                out_valid <= 1'b1;
                out_data  <= div_zero ? 8'h00 : ops_y;
                out_err   <= div_zero;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ops_seq.sv
// Self-checking bench for ops_seq: queue-based reference model compared every
// cycle, plus directed scenarios with literal expected values.
module tb_ops_seq;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_a = '0;
    logic [7:0]       in_b = '0;
    logic [1:0]       in_op = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [7:0]       out_data;
    logic             out_err;
    logic             busy;
    logic [CNT_W-1:0] done_cnt;

    int ntests = 0;
    int nfail  = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    ops_seq #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result: {err, data}
    function automatic logic [8:0] calc(input logic [1:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] s;
        case (op)
            2'd0: begin s = a + b; return {1'b0, s}; end
            2'd1: begin
                if (b == 8'd0) return {1'b1, 8'h00};
                s = a % b;
                return {1'b0, s};
            end
            2'd2: return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    // Reference model: pending command queue plus one output slot.
    logic [17:0]      mq[$];
    logic             m_valid = 1'b0;
    logic [7:0]       m_data = '0;
    logic             m_err = 1'b0;
    logic [CNT_W-1:0] m_done = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_err   = 1'b0;
            m_done  = '0;
        end else begin
            bit hs, iss, acc;
            logic [17:0] e;
            logic [8:0]  r;
            hs  = m_valid && out_ready;
            iss = (mq.size() > 0) && (!m_valid || out_ready);
            acc = in_valid && (mq.size() < DEPTH);
            if (hs) m_done = m_done + 1'b1;
            if (iss) begin
                e = mq.pop_front();
                r = calc(e[17:16], e[7:0], e[15:8]);
                m_valid = 1'b1;
                m_data  = r[7:0];
                m_err   = r[8];
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (acc) mq.push_back({in_op, in_b, in_a});
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("in_ready", in_ready, rst_n && (mq.size() < DEPTH));
            check("out_valid", out_valid, m_valid);
            check("busy", busy, (mq.size() > 0) || m_valid);
            check("done_cnt", done_cnt, m_done);
            if (m_valid) begin
                check("out_data", out_data, m_data);
                check("out_err", out_err, m_err);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        int n = 0;
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        while (!in_ready && n < 50) begin step(); n++; end
        check("send_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
    endtask

    // Single command into an idle stage with out_ready high.
    task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                           input logic [7:0] exp_d, input logic exp_e, input string name);
        send(a, b, op);
        step();
        check({name, "_valid"}, out_valid, 1'b1);
        check({name, "_data"}, out_data, exp_d);
        check({name, "_err"}, out_err, exp_e);
        step();
        check({name, "_valid_drop"}, out_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got[$];
        int         got_idx[$];
        int         ov_cnt;
        int         n;

        // Reset
        step();
        cmp_en = 1'b1;
        step();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done_cnt, 0);
        rst_n = 1'b1;
        step();

        // Basic arithmetic
        run_one(8'd200, 8'd100, 2'b00, 8'd44, 1'b0, "add_wrap");
        check("done_after_add", done_cnt, 1);
        run_one(8'd23, 8'd5, 2'b01, 8'd3, 1'b0, "mod");
        run_one(8'd23, 8'd0, 2'b01, 8'h00, 1'b1, "mod_zero");
        run_one(8'hF0, 8'h3C, 2'b10, 8'h30, 1'b0, "and");
        check("done_after_basic", done_cnt, 4);

        // Backpressure: one held in output, four in the FIFO, sixth stalled
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(8'(10 * i), 8'(i), 2'b00);
        check("full_in_ready", in_ready, 1'b0);
        check("held_valid", out_valid, 1'b1);
        check("held_data", out_data, 8'd11);
        in_a = 8'd60; in_b = 8'd6; in_op = 2'b00; in_valid = 1'b1;
        step(); step(); step();
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_data", out_data, 8'd11);
        check("stall_done", done_cnt, 4);
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bit acc;
            acc = in_valid && in_ready;
            if (out_valid) begin
                got.push_back(out_data);
                got_idx.push_back(k);
            end
            step();
            if (acc) in_valid = 1'b0;
        end
        check("drain_in_valid_dropped", in_valid, 1'b0);
        check("drain_count", got.size(), 6);
        if (got.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                check("drain_order", got[k], 8'(11 * (k + 1)));
                check("drain_consecutive", got_idx[k], k);
            end
        end
        check("done_after_drain", done_cnt, 10);

        // Back-to-back stream of 16 OR commands
        ov_cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            in_a = 8'(i); in_b = 8'h80; in_op = 2'b11; in_valid = 1'b1;
            step();
            if (out_valid) ov_cnt++;
        end
        in_valid = 1'b0;
        step();
        if (out_valid) ov_cnt++;
        check("stream_last_data", out_data, 8'h90);
        check("stream_busy_last", busy, 1'b1);
        step();
        check("stream_ov_cycles", ov_cnt, 16);
        check("stream_out_valid_end", out_valid, 1'b0);
        check("stream_busy_end", busy, 1'b0);
        check("stream_done", done_cnt, 26);

        // Reset with queued and pending results
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(i + 1), 8'd2, 2'b00);
        check("pre_rst_busy", busy, 1'b1);
        check("pre_rst_full_ish", in_ready, 1'b1);
        rst_n = 1'b0;
        step();
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done_cnt, 0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (out_valid) n++;
        end
        check("post_rst_no_stale", n, 0);

        // Counter wrap: 65535 handshakes then one more
        in_a = 8'd1; in_b = 8'd1; in_op = 2'b00; in_valid = 1'b1;
        for (int k = 0; k < 65535; k++) step();
        in_valid = 1'b0;
        step();
        step();
        check("wrap_pre", done_cnt, 16'hFFFF);
        run_one(8'd7, 8'd9, 2'b00, 8'd16, 1'b0, "wrap_add");
        check("wrap_post", done_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
